// File: rtl/wave_gen_multi_pkg.sv
// Shared types for the multi-mode waveform generator: waveform mode encoding.
package wave_gen_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW_UP = 2'd1,
    MODE_SAW_DN = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

endpackage

// File: rtl/wave_gen_multi_if.sv
// Control/sample bundle between a stimulus source (master) and the generator (slave).
interface wave_gen_multi_if
  import wave_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic              en;
  mode_e             mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  peak;
  logic [WIDTH-1:0]  wave;
  logic              dir;
  logic              cycle_done;

  modport master (
    output en, mode, step, peak,
    input  wave, dir, cycle_done
  );

  modport slave (
    input  en, mode, step, peak,
    output wave, dir, cycle_done
  );

endinterface

// File: rtl/wave_cfg_shadow.sv
// Active configuration shadow: samples mode/step/peak during reset and at each
// enabled period boundary, so mid-period input changes cannot glitch the output.
module wave_cfg_shadow
  import wave_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_done_nx,
  input  mode_e             i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_peak,
  output mode_e             o_mode,
  output logic [STEP_W-1:0] o_step,
  output logic [WIDTH-1:0]  o_peak,
  output logic              o_reload
);

  mode_e             r_mode;
  logic [STEP_W-1:0] r_step;
  logic [WIDTH-1:0]  r_peak;
  logic              w_reload;

  // Reload on the same edge that produces the cycle_done pulse.
  assign w_reload = rst | (i_en & i_done_nx);

  always_ff @(posedge clk) begin
    if (w_reload) begin
      r_mode <= i_mode;
      r_step <= i_step;
      r_peak <= i_peak;
    end
  end

  assign o_mode   = r_mode;
  assign o_step   = r_step;
  assign o_peak   = r_peak;
  assign o_reload = w_reload;

endmodule

// File: rtl/wave_gen_multi.sv
// Multi-mode periodic waveform generator: triangle, rising/falling sawtooth and
// square output with registered sample, phase flag and period-start pulse.
module wave_gen_multi
  import wave_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  wave_gen_multi_if.slave  bus
);

  localparam int XW = WIDTH + 1;

  mode_e             w_mode;
  logic [STEP_W-1:0] w_step;
  logic [WIDTH-1:0]  w_peak;
  logic              w_reload;

  logic [WIDTH-1:0]  r_wave;
  logic              r_dir;
  logic              r_done;
  logic [STEP_W-1:0] r_cnt;
  logic              r_lvl;

  logic [WIDTH-1:0]  w_wave_nx;
  logic              w_dir_nx;
  logic              w_done_nx;
  logic [STEP_W-1:0] w_cnt_nx;
  logic              w_lvl_nx;

  logic [XW-1:0]     w_sum;
  logic [XW-1:0]     w_wave_x;
  logic [XW-1:0]     w_step_x;
  logic [XW-1:0]     w_peak_x;
  logic [WIDTH-1:0]  w_diff;

  wave_cfg_shadow #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .i_en      (bus.en),
    .i_done_nx (w_done_nx),
    .i_mode    (bus.mode),
    .i_step    (bus.step),
    .i_peak    (bus.peak),
    .o_mode    (w_mode),
    .o_step    (w_step),
    .o_peak    (w_peak),
    .o_reload  (w_reload)
  );

  // One extra bit of headroom so wave+step never wraps before the peak compare.
  assign w_wave_x = {1'b0, r_wave};
  assign w_step_x = XW'(w_step);
  assign w_peak_x = {1'b0, w_peak};
  assign w_sum    = w_wave_x + w_step_x;
  assign w_diff   = r_wave - WIDTH'(w_step);

  always_comb begin
    w_wave_nx = r_wave;
    w_dir_nx  = r_dir;
    w_done_nx = 1'b0;
    w_cnt_nx  = r_cnt;
    w_lvl_nx  = r_lvl;
    case (w_mode)
      MODE_TRI: begin
        if (r_dir) begin
          if (w_sum >= w_peak_x) begin
            w_wave_nx = w_peak;
            w_dir_nx  = 1'b0;
          end else begin
            w_wave_nx = w_sum[WIDTH-1:0];
          end
        end else begin
          if (w_wave_x <= w_step_x) begin
            w_wave_nx = '0;
            w_dir_nx  = 1'b1;
            w_done_nx = 1'b1;
          end else begin
            w_wave_nx = w_diff;
          end
        end
      end
      MODE_SAW_UP: begin
        w_dir_nx = 1'b1;
        if (r_wave >= w_peak) begin
          w_wave_nx = '0;
          w_done_nx = 1'b1;
        end else if (w_sum >= w_peak_x) begin
          w_wave_nx = w_peak;
        end else begin
          w_wave_nx = w_sum[WIDTH-1:0];
        end
      end
      MODE_SAW_DN: begin
        w_dir_nx = 1'b0;
        if (r_wave == '0) begin
          w_wave_nx = w_peak;
          w_done_nx = 1'b1;
        end else if (w_wave_x <= w_step_x) begin
          w_wave_nx = '0;
        end else begin
          w_wave_nx = w_diff;
        end
      end
      MODE_SQUARE: begin
        if (r_cnt == w_step) begin
          w_cnt_nx  = '0;
          w_lvl_nx  = ~r_lvl;
          w_wave_nx = r_lvl ? '0 : w_peak;
          w_done_nx = r_lvl;
          w_dir_nx  = ~r_lvl;
        end else begin
          w_cnt_nx  = r_cnt + STEP_W'(1);
          w_wave_nx = r_lvl ? w_peak : '0;
          w_dir_nx  = r_lvl;
        end
      end
      default: begin
        w_wave_nx = r_wave;
      end
    endcase
  end

  // On a reload edge the phase state restarts; the sample itself still comes
  // from the outgoing config so the boundary value is produced cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wave <= '0;
      r_dir  <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
    end else if (bus.en) begin
      r_wave <= w_wave_nx;
      r_done <= w_done_nx;
      if (w_reload) begin
        r_dir <= 1'b1;
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else begin
        r_dir <= w_dir_nx;
        r_cnt <= w_cnt_nx;
        r_lvl <= w_lvl_nx;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign bus.wave       = r_wave;
  assign bus.dir        = r_dir;
  assign bus.cycle_done = r_done;

endmodule
